fft_in_unpack: RTL

//   Feed-side counterpart of the FFT output packer: it takes a 1024-bit frame
//   the MCU has shifted into the SPI slave shift register and streams it into
//   the FFT core as 32-bit words.
//   - Detects end of SPI frame (cs high->low, synchronised into clk domain).
//   - Snapshots the frame, then issues words MSB-first with valid/ready,

---
 rtl/fft_in_unpack.sv | 107 ++++++++++
 1 files changed

// File: rtl/fft_in_unpack.sv
// Captures a SPI-shifted frame on cs fall and streams it MSW-first to the FFT, then pulses start and waits for done.
// First valid arrives SYNC_STAGES+2 clocks after cs falls; a word is held while fft_in_ready_i is low.
module fft_in_unpack #(
    parameter int FRAME_W     = 1024,
    parameter int WORD_W      = 32,
    parameter int SYNC_STAGES = 2,
    localparam int NW         = FRAME_W / WORD_W,
    localparam int AW         = $clog2(NW)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               cs_i,
    input  logic [FRAME_W-1:0] spi_q_i,
    output logic [WORD_W-1:0]  fft_in32_o,
    output logic               fft_in_valid_o,
    input  logic               fft_in_ready_i,
    output logic [AW-1:0]      fft_addr_o,
    output logic               fft_load_o,
    output logic               fft_start_o,
    input  logic               fft_done_i,
    output logic               busy_o,
    output logic               overrun_o
);

    typedef enum logic [1:0] {IDLE, LOAD, START, BUSY} state_t;

    state_t                      state_q, state_d;
    logic [SYNC_STAGES-1:0]      sync_q;
    logic                        prev_q;
    logic                        fe_q;
    logic [AW-1:0]               cnt_q, cnt_d;
    logic [NW-1:0][WORD_W-1:0]   buf_q, buf_d;
    logic                        ovr_q, ovr_d;

    // cs is asynchronous; only the synchronised copy feeds the edge detector.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cs_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            fe_q   <= prev_q & ~sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        ovr_d   = ovr_q;
        // A frame end outside IDLE (including the cycle BUSY exits) is dropped.
        if (fe_q && state_q != IDLE) begin
            ovr_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (fe_q) begin
                    buf_d   = spi_q_i;
                    ovr_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (fft_in_ready_i) begin
                    if (cnt_q == AW'(NW - 1)) begin
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            START: state_d = BUSY;
            BUSY: begin
                if (fft_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fft_in32_o     = buf_q[AW'(NW - 1) - cnt_q];
    assign fft_addr_o     = cnt_q;
    assign fft_in_valid_o = (state_q == LOAD);
    assign fft_load_o     = (state_q == LOAD);
    assign fft_start_o    = (state_q == START);
    assign busy_o         = (state_q != IDLE);
    assign overrun_o      = ovr_q;

endmodule
